// File: rtl/dsi_pkt_sink.sv
`timescale 1ns/1ps
// rtl/dsi_pkt_sink.sv - packet-request responder: paces dreq, rebuilds video timing, measures frame geometry
module dsi_pkt_sink #(
  parameter int g_pixels_per_clock = 1,
  parameter int g_hdr_gap          = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            p_req_i,
  input  logic                            p_islong_i,
  input  logic [5:0]                      p_type_i,
  input  logic [15:0]                     p_wcount_i,
  input  logic [15:0]                     p_command_i,
  input  logic [24*g_pixels_per_clock-1:0] p_payload_i,
  input  logic                            p_last_i,
  output logic                            p_dreq_o,
  output logic                            vid_vsync_o,
  output logic                            vid_hsync_o,
  output logic                            vid_de_o,
  output logic [24*g_pixels_per_clock-1:0] vid_pixels_o,
  output logic                            frame_done_o,
  input  logic [3:0]                      host_a_i,
  input  logic [7:0]                      host_d_i,
  output logic [7:0]                      host_d_o,
  input  logic                            host_wr_i
);
  // Packet data types emitted by the timing generator
  localparam logic [5:0]  PTYPE_VSYNC_START = 6'h01;
  localparam logic [5:0]  PTYPE_HSYNC_START = 6'h21;
  localparam logic [5:0]  PTYPE_BLANKING    = 6'h19;
  localparam logic [5:0]  PTYPE_RGB24       = 6'h3E;
  localparam logic [15:0] BEAT_BYTES        = 16'(3 * g_pixels_per_clock);
  localparam logic [7:0]  GAP_LAST          = 8'((g_hdr_gap > 0) ? g_hdr_gap - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR_REQ, ST_HDR_CAP, ST_PAYLOAD, ST_TAIL, ST_GAP, ST_DONE
  } state_t;

  state_t r_state, w_next, w_post, w_after_pkt;
  logic   w_dreq, w_abort, w_cap, w_last_now, w_clr;
  logic   w_is_vs, w_is_hs, w_is_bl, w_is_rgb, w_known, w_wc_rem;
  logic [4:0] w_new_err;
  logic   w_unused_host_d;

  logic [15:0] r_bytes;
  logic [11:0] r_wcount;
  logic        r_rgb, r_last, r_take;
  logic [7:0]  r_gap;
  logic [11:0] r_line_cnt, r_meas_v, r_meas_h;
  logic [4:0]  r_err;
  logic [7:0]  r_frames;
  logic        r_vsync, r_hsync, r_de, r_frame_done;
  logic [24*g_pixels_per_clock-1:0] r_pix;
  logic [7:0]  r_host_d;

  assign w_unused_host_d = &host_d_i;   // write data is don't-care: any write to addr 3 clears

  assign w_abort    = !p_req_i && (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_cap      = (r_state == ST_HDR_CAP) && !w_abort;
  assign w_is_vs    = (p_type_i == PTYPE_VSYNC_START);
  assign w_is_hs    = (p_type_i == PTYPE_HSYNC_START);
  assign w_is_bl    = (p_type_i == PTYPE_BLANKING);
  assign w_is_rgb   = (p_type_i == PTYPE_RGB24);
  assign w_known    = w_is_vs | w_is_hs | w_is_bl | w_is_rgb;
  assign w_wc_rem   = (p_wcount_i % BEAT_BYTES) != 16'd0;
  assign w_new_err  = {w_cap && (p_command_i != 16'd0),
                       w_abort,
                       w_cap && (((w_is_vs || w_is_hs) && p_islong_i) || (w_is_rgb && !p_islong_i)),
                       w_cap && p_islong_i && w_wc_rem,
                       w_cap && !w_known};
  assign w_clr      = host_wr_i && (host_a_i == 4'd3);

  // Header's last flag is only live on the capture cycle; afterwards use the latched copy
  assign w_last_now  = (r_state == ST_HDR_CAP) ? p_last_i : r_last;
  assign w_post      = w_last_now ? ST_DONE : (p_req_i ? ST_HDR_REQ : ST_IDLE);
  // A zero gap skips ST_GAP entirely so headers can come every second cycle
  assign w_after_pkt = (g_hdr_gap > 0) ? ST_GAP : w_post;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and dreq pacing; a dropped request overrides everything
  always_comb begin
    w_next = r_state;
    w_dreq = 1'b0;
    case (r_state)
      ST_IDLE:    if (p_req_i) w_next = ST_HDR_REQ;
      ST_HDR_REQ: begin
        w_dreq = 1'b1;
        w_next = ST_HDR_CAP;
      end
      ST_HDR_CAP: w_next = (p_islong_i && (p_wcount_i != 16'd0)) ? ST_PAYLOAD : w_after_pkt;
      ST_PAYLOAD: begin
        w_dreq = 1'b1;
        if (r_bytes <= BEAT_BYTES) w_next = ST_TAIL;
      end
      ST_TAIL:    w_next = w_after_pkt;
      ST_GAP:     if (r_gap == GAP_LAST) w_next = w_post;
      ST_DONE:    if (!p_req_i) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next = ST_IDLE;
      w_dreq = 1'b0;
    end
  end

  // Header latch, byte countdown, video rebuild, measurements and sticky errors
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_bytes <= '0; r_wcount <= '0; r_rgb <= 1'b0; r_last <= 1'b0; r_take <= 1'b0;
      r_gap <= '0; r_line_cnt <= '0; r_meas_v <= '0; r_meas_h <= '0; r_err <= '0;
      r_frames <= '0; r_vsync <= 1'b0; r_hsync <= 1'b0; r_de <= 1'b0; r_pix <= '0;
      r_frame_done <= 1'b0;
    end else begin
      // beat requested this cycle arrives next cycle and is shown the cycle after
      r_take  <= (r_state == ST_PAYLOAD) && !w_abort;
      r_de    <= r_take && r_rgb;
      r_pix   <= (r_take && r_rgb) ? p_payload_i : '0;
      r_vsync <= w_cap && w_is_vs;
      r_hsync <= w_cap && w_is_hs;
      r_gap   <= (r_state == ST_GAP) ? r_gap + 8'd1 : 8'd0;
      if (w_cap) begin
        r_bytes  <= p_wcount_i;
        r_wcount <= p_wcount_i[11:0];
        r_rgb    <= w_is_rgb && p_islong_i;
        r_last   <= p_last_i;
      end else if (r_state == ST_PAYLOAD) begin
        r_bytes  <= (r_bytes > BEAT_BYTES) ? r_bytes - BEAT_BYTES : 16'd0;
      end
      if (w_cap && w_is_vs) begin
        r_meas_v   <= r_line_cnt;
        r_line_cnt <= '0;
      end else if (w_cap && w_is_hs && (r_line_cnt != 12'hFFF)) begin
        r_line_cnt <= r_line_cnt + 12'd1;
      end
      if ((r_state == ST_TAIL) && r_rgb && !w_abort) r_meas_h <= r_wcount;
      r_frame_done <= (w_next == ST_DONE) && (r_state != ST_DONE);
      if ((w_next == ST_DONE) && (r_state != ST_DONE)) r_frames <= r_frames + 8'd1;
      r_err <= (w_clr ? 5'd0 : r_err) | w_new_err;
    end
  end

  // Registered host read port
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_host_d <= '0;
    end else begin
      case (host_a_i)
        4'd0:    r_host_d <= r_meas_h[7:0];
        4'd1:    r_host_d <= {r_meas_h[11:8], r_meas_v[11:8]};
        4'd2:    r_host_d <= r_meas_v[7:0];
        4'd3:    r_host_d <= {3'b000, r_err};
        4'd4:    r_host_d <= r_frames;
        default: r_host_d <= 8'd0;
      endcase
    end
  end

  assign p_dreq_o     = w_dreq;
  assign vid_vsync_o  = r_vsync;
  assign vid_hsync_o  = r_hsync;
  assign vid_de_o     = r_de;
  assign vid_pixels_o = r_pix;
  assign frame_done_o = r_frame_done;
  assign host_d_o     = r_host_d;
endmodule
